// File: rtl/fv_ccp_single_rd_port_queue.sv
// Read-port queue for the CCP data array. Credit-gated requests go to the array.
// Returning data lands in a response FIFO, or passes straight through when the FIFO is empty.
module fv_ccp_single_rd_port_queue #(
  parameter int RD_QUEUE_DEPTH = 4,
  parameter int PNT_W          = $clog2(RD_QUEUE_DEPTH),
  parameter int CNT_W          = $clog2(RD_QUEUE_DEPTH + 1),
  parameter int MEM_W          = 4,
  parameter int ADDR_W         = 4,
  parameter int RD_LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_req_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [MEM_W-1:0]  mem_rd_data,
  output logic              rsp_valid,
  output logic [MEM_W-1:0]  rsp_data,
  input  logic              rsp_pop,
  output logic [CNT_W-1:0]  inflight_cnt,
  output logic              empty,
  output logic              full
);

  localparam int CW1 = CNT_W + 1;
  localparam logic [PNT_W-1:0] LAST_PNT = PNT_W'(RD_QUEUE_DEPTH - 1);

  logic [PNT_W-1:0]      wr_pnt_q, wr_pnt_d, rd_pnt_q, rd_pnt_d;
  logic [CNT_W-1:0]      occ_q, occ_d, infl_q, infl_d;
  logic [RD_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [MEM_W-1:0]      mem_q [RD_QUEUE_DEPTH];
  logic [CNT_W:0]        credit_used;
  logic                  accept, arrive, write, take_fifo;

  // Credits count both queued entries and reads still in the array pipe.
  assign credit_used  = {1'b0, occ_q} + {1'b0, infl_q};
  assign rd_req_ready = credit_used < CW1'(RD_QUEUE_DEPTH);
  assign accept       = rd_req && rd_req_ready;
  assign mem_rd_en    = accept;
  assign mem_rd_addr  = rd_addr;

  assign arrive       = vld_sr_q[RD_LATENCY-1];
  assign empty        = (occ_q == '0);
  assign full         = (occ_q == CNT_W'(RD_QUEUE_DEPTH));
  assign inflight_cnt = infl_q;
  assign rsp_valid    = !empty || arrive;
  assign rsp_data     = empty ? mem_rd_data : mem_q[rd_pnt_q];

  // An arrival popped against an empty FIFO bypasses storage entirely.
  assign write     = arrive && !(empty && rsp_pop);
  assign take_fifo = rsp_pop && !empty;

  always_comb begin
    vld_sr_d    = '0;
    vld_sr_d[0] = accept;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end
    wr_pnt_d = wr_pnt_q;
    rd_pnt_d = rd_pnt_q;
    if (write) begin
      wr_pnt_d = (wr_pnt_q == LAST_PNT) ? '0 : wr_pnt_q + 1'b1;
    end
    if (take_fifo) begin
      rd_pnt_d = (rd_pnt_q == LAST_PNT) ? '0 : rd_pnt_q + 1'b1;
    end
    occ_d  = occ_q + CNT_W'(write) - CNT_W'(take_fifo);
    infl_d = infl_q + CNT_W'(accept) - CNT_W'(arrive);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_pnt_q <= '0;
      rd_pnt_q <= '0;
      occ_q    <= '0;
      infl_q   <= '0;
      vld_sr_q <= '0;
    end else begin
      wr_pnt_q <= wr_pnt_d;
      rd_pnt_q <= rd_pnt_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      vld_sr_q <= vld_sr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write) begin
      mem_q[wr_pnt_q] <= mem_rd_data;
    end
  end

`ifndef SYNTHESIS
  pop_only_when_valid: assume property (@(posedge clk) disable iff (!reset_n)
    rsp_pop |-> rsp_valid);
  req_held_until_accepted: assume property (@(posedge clk) disable iff (!reset_n)
    rd_req && !rd_req_ready |=> rd_req && $stable(rd_addr));
  credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
    credit_used <= CW1'(RD_QUEUE_DEPTH));
  no_write_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(full && write));
  no_arrive_without_issue: assert property (@(posedge clk) disable iff (!reset_n)
    arrive |-> infl_q != '0);
`endif

endmodule

// File: tb/tb_fv_ccp_single_rd_port_queue.sv
// Randomized scoreboard bench for the CCP read-port queue.
// Every accepted read is queued with its issue cycle and data; a negedge monitor derives all outputs from that queue.
module tb_fv_ccp_single_rd_port_queue;
  localparam int DEPTH = 3;
  localparam int LAT   = 2;
  localparam int AW    = 4;
  localparam int MW    = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rd_req = 1'b0;
  logic          rsp_pop = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [MW-1:0] mem_rd_data = '0;
  logic          rd_req_ready, mem_rd_en, rsp_valid, empty, full;
  logic [AW-1:0] mem_rd_addr;
  logic [MW-1:0] rsp_data;
  logic [CW-1:0] inflight_cnt;

  typedef struct {
    int            acc;
    logic [MW-1:0] data;
  } item_t;

  item_t         expQ[$];
  logic [MW-1:0] content [16];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  bit            holdReq = 1'b0;

  fv_ccp_single_rd_port_queue #(
    .RD_QUEUE_DEPTH(DEPTH), .MEM_W(MW), .ADDR_W(AW), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_req_ready(rd_req_ready), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_pop(rsp_pop), .inflight_cnt(inflight_cnt), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reads accepted in earlier cycles and not yet consumed hold a credit.
  function automatic int outstanding();
    int n = 0;
    foreach (expQ[k]) if (expQ[k].acc < cyc) n++;
    return n;
  endfunction

  // Data is stored once its return cycle has passed without being consumed.
  function automatic int occupancy();
    int n = 0;
    foreach (expQ[k]) if (expQ[k].acc + LAT <= cyc - 1) n++;
    return n;
  endfunction

  function automatic int inflight();
    int n = 0;
    foreach (expQ[k]) if (expQ[k].acc < cyc && expQ[k].acc + LAT >= cyc) n++;
    return n;
  endfunction

  function automatic bit modelValid();
    return expQ.size() > 0 && expQ[0].acc + LAT <= cyc;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every output against the scoreboard, then retire popped entries.
  always @(negedge clk) begin
    bit v;
    bit rdy;
    int occ;
    if (!reset_n) begin
      checkOutput("reset_ready", 32'(rd_req_ready), 32'd1);
      checkOutput("reset_en", 32'(mem_rd_en), 32'd0);
      checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_empty", 32'(empty), 32'd1);
      checkOutput("reset_full", 32'(full), 32'd0);
      checkOutput("reset_inflight", 32'(inflight_cnt), 32'd0);
    end else begin
      v   = modelValid();
      rdy = outstanding() < DEPTH;
      occ = occupancy();
      checkOutput("rd_req_ready", 32'(rd_req_ready), 32'(rdy));
      checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(rd_req && rdy));
      if (rd_req && rdy) checkOutput("mem_rd_addr", 32'(mem_rd_addr), 32'(rd_addr));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(v));
      checkOutput("empty", 32'(empty), 32'(occ == 0));
      checkOutput("full", 32'(full), 32'(occ == DEPTH));
      checkOutput("inflight_cnt", 32'(inflight_cnt), 32'(inflight()));
      if (v) checkOutput("rsp_data", 32'(rsp_data), 32'(expQ[0].data));
      if (rsp_pop && v) void'(expQ.pop_front());
    end
  end

  task automatic applyStimulus(input int cycles, input int reqPct, input int popPct);
    logic [MW-1:0] md;
    bit rdy;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      md = MW'($urandom);
      foreach (expQ[k]) if (expQ[k].acc + LAT == cyc) md = expQ[k].data;
      mem_rd_data = md;
      if (!holdReq) begin
        rd_req  = ($urandom_range(99) < reqPct);
        rd_addr = AW'($urandom);
      end
      rsp_pop = modelValid() && ($urandom_range(99) < popPct);
      rdy = outstanding() < DEPTH;
      if (rd_req && rdy) expQ.push_back('{acc: cyc, data: content[rd_addr]});
      holdReq = rd_req && !rdy;
    end
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rd_req      = 1'b0;
    rsp_pop     = 1'b0;
    holdReq     = 1'b0;
    mem_rd_data = MW'($urandom);
    reset_n     = 1'b0;
    expQ.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    foreach (content[i]) content[i] = MW'($urandom);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(8, 100, 0);
    applyStimulus(8, 0, 100);
    applyStimulus(200, 50, 50);
    applyStimulus(100, 40, 100);
    applyStimulus(10, 0, 100);
    applyStimulus(3, 100, 0);
    pulseReset();
    applyStimulus(6, 0, 0);
    applyStimulus(300, 60, 40);
    applyStimulus(30, 0, 100);
    @(posedge clk);
    #1;
    checkOutput("drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fv_ccp_single_rd_port_queue.md
Name: fv_ccp_single_rd_port_queue

Overview:
Formal/DV model of the CCP data-array read port; the reader-side counterpart of the single-write-port queue. Accepts read requests under credit flow control and issues them to the array model. Captures array data after a fixed latency into a response FIFO. Includes an empty-queue bypass path and the environment constraints needed for formal runs.

Parameters:
RD_QUEUE_DEPTH, 4, response FIFO entries and maximum outstanding-plus-queued reads (>=2; non-power-of-2 allowed)
PNT_W, $clog2(RD_QUEUE_DEPTH), FIFO pointer width
CNT_W, $clog2(RD_QUEUE_DEPTH+1), occupancy/in-flight counter width
MEM_W, 4, read data width
ADDR_W, 4, read address width
RD_LATENCY, 2, cycles from mem_rd_en to mem_rd_data valid (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
rd_req  in  1  read request
rd_addr  in  ADDR_W  request address
rd_req_ready  out  1  credit available; request accepted when rd_req && rd_req_ready
mem_rd_en  out  1  array read strobe
mem_rd_addr  out  ADDR_W  array read address
mem_rd_data  in  MEM_W  array data, valid RD_LATENCY cycles after mem_rd_en
rsp_valid  out  1  response available
rsp_data  out  MEM_W  response data
rsp_pop  in  1  consumer takes response
inflight_cnt  out  CNT_W  issued reads not yet returned
empty  out  1  FIFO holds no entries
full  out  1  FIFO holds RD_QUEUE_DEPTH entries

Behaviour:
- Reset (async): wr_pnt, rd_pnt, occupancy, inflight_cnt, and the latency shift register all clear. Outputs: rd_req_ready=1, mem_rd_en=0, rsp_valid=0, empty=1, full=0, inflight_cnt=0. FIFO storage is not reset.
- accept = rd_req && rd_req_ready. mem_rd_en = accept and mem_rd_addr = rd_addr, both combinational (zero latency).
- rd_req_ready = (occupancy + inflight_cnt) < RD_QUEUE_DEPTH. Computed from registered state only; a same-cycle pop does not raise it. Ready rises the cycle after the pop.
- Latency tracking: vld_sr[RD_LATENCY-1:0]. vld_sr[0] <= accept; the register shifts every cycle. arrive = vld_sr[RD_LATENCY-1].
- inflight_cnt <= inflight_cnt + accept - arrive.
- rsp_valid = !empty || arrive.
- rsp_data = empty ? mem_rd_data : mem[rd_pnt].
- take = rsp_pop && rsp_valid.
- Bypass: when arrive && empty && rsp_pop, the data passes straight through. No write occurs, pointers hold, and empty stays 1.
- Write: when arrive && !(empty && rsp_pop), mem[wr_pnt] <= mem_rd_data and wr_pnt advances.
- Read: when rsp_pop && !empty, rd_pnt advances.
- Pointers wrap from RD_QUEUE_DEPTH-1 to 0.
- occupancy <= occupancy + write - (rsp_pop && !empty). Simultaneous write and pop while non-empty leaves occupancy unchanged.
- empty = (occupancy==0); full = (occupancy==RD_QUEUE_DEPTH). Credit control guarantees no write while full.
- Reset mid-operation: in-flight reads are discarded (vld_sr cleared). mem_rd_data returning after reset is ignored.
- Assertions, environment constraints (assume in formal):
  - pop_only_when_valid: rsp_pop |-> rsp_valid
  - req_held_until_accepted: rd_req && !rd_req_ready |=> rd_req && $stable(rd_addr)
- Assertions, internal checks:
  - credit_bound: occupancy + inflight_cnt <= RD_QUEUE_DEPTH
  - no_write_when_full: !(full && write)
  - no_arrive_without_issue: arrive |-> inflight_cnt != 0
- All assertions are disabled while !reset_n.

Test Plan:
1. Single read, defaults. rd_req with addr 3 at cycle 0 -> mem_rd_en=1 and mem_rd_addr=3 at cycle 0. Drive mem_rd_data=0xA at cycle 2 -> rsp_valid=1, rsp_data=0xA at cycle 2; empty=0 from cycle 3. Pop at cycle 5 -> empty=1 and rsp_valid=0 at cycle 6.
2. Bypass. FIFO empty, data 0x5 arrives with rsp_pop=1 -> rsp_data=0x5 that cycle; empty stays 1 and wr_pnt is unchanged.
3. Credit stall. Four back-to-back requests at cycles 0-3, no pops -> rd_req_ready=0 from cycle 4 and full=1 from cycle 6. Pop at cycle 7 -> rd_req_ready=1 at cycle 8.
4. Wrap, RD_QUEUE_DEPTH=3. Seven reads return data 1..7 with interleaved pops -> responses arrive in order 1..7 and both pointers wrap 2->0 at least twice.
5. Simultaneous pop and arrive. FIFO holds 0x1; 0x2 arrives with rsp_pop -> rsp_data=0x1 that cycle, occupancy stays 1, rsp_data=0x2 next cycle.
6. Reset mid-operation. Two reads in flight and one queued; pulse reset_n low for one cycle -> all outputs at reset values. Data returning afterwards produces no rsp_valid, and inflight_cnt=0.
